// File: rtl/yc_cvbs_mix_if.sv
// Y/C-to-composite mixer port bundle: video and sync inputs from the source,
// composite code plus aligned blank/sync flags back to the sink.
interface yc_cvbs_mix_if;
    logic       pal_en;
    logic [7:0] y_in;
    logic [7:0] c_in;
    logic       hsync_in;
    logic       vsync_in;
    logic       csync_in;
    logic [7:0] cvbs;
    logic       blank_o;
    logic       sync_o;

    modport master (
        output pal_en, y_in, c_in, hsync_in, vsync_in, csync_in,
        input  cvbs, blank_o, sync_o
    );

    modport slave (
        input  pal_en, y_in, c_in, hsync_in, vsync_in, csync_in,
        output cvbs, blank_o, sync_o
    );
endinterface

// File: rtl/yc_cvbs_mix.sv
// Mixes luma and modulated chroma into an 8-bit composite code, 3-clock latency.
// Define CVBS_SETUP_EN to add the NTSC pedestal (SETUP_LVL) during active video.
module yc_cvbs_mix #(
    parameter logic [10:0] BP_LEN    = 11'd400,
    parameter logic [7:0]  BLANK_LVL = 8'd72,
    parameter logic [7:0]  SETUP_LVL = 8'd10
) (
    input logic          clk,
    input logic          reset,
    yc_cvbs_mix_if.slave bus
);
    typedef enum logic [1:0] {SYNC, PORCH, ACTIVE, VBL} line_state_t;

    line_state_t state;
    logic [10:0] cnt;
    logic        cs_raw;
    logic        csq;
    logic [7:0]  y_d1, y_d2, c_d1, c_d2;
    logic        vs_d1, vs_d2, sy_d1, sy_d2, pal_d1, pal_d2;

    logic [15:0] prod;
    logic [10:0] ys, cs, ped, sum;
    logic [7:0]  level;
    logic        unused_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_raw <= 1'b0;
            csq    <= 1'b0;
        end else begin
            cs_raw <= bus.csync_in;
            if (bus.csync_in == cs_raw)
                csq <= bus.csync_in;
        end
    end

    // Cleared chroma is 128 so post-reset porch pixels sit at blanking level.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_d1   <= '0;
            y_d2   <= '0;
            c_d1   <= 8'd128;
            c_d2   <= 8'd128;
            vs_d1  <= 1'b0;
            vs_d2  <= 1'b0;
            sy_d1  <= 1'b0;
            sy_d2  <= 1'b0;
            pal_d1 <= 1'b0;
            pal_d2 <= 1'b0;
        end else begin
            y_d1   <= bus.y_in;
            y_d2   <= y_d1;
            c_d1   <= bus.c_in;
            c_d2   <= c_d1;
            vs_d1  <= bus.vsync_in;
            vs_d2  <= vs_d1;
            sy_d1  <= bus.csync_in;
            sy_d2  <= sy_d1;
            pal_d1 <= bus.pal_en;
            pal_d2 <= pal_d1;
        end
    end

    // The registered csq trails stage-1 data by one clock, so state lines up with stage 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SYNC;
            cnt   <= '0;
        end else if (csq) begin
            state <= SYNC;
        end else begin
            case (state)
                SYNC: begin
                    state <= PORCH;
                    cnt   <= '0;
                end
                PORCH: begin
                    if (cnt == BP_LEN - 11'd1)
                        state <= vs_d2 ? VBL : ACTIVE;
                    if (cnt != '1)
                        cnt <= cnt + 11'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        prod = 16'(y_d2) * 16'd183;
        ys   = (state == ACTIVE) ? {3'b000, prod[15:8]} : '0;
        // Offset-binary minus 128, halved arithmetically, sign-extended to 11 bits.
        cs   = (state == SYNC) ? '0 : {{4{~c_d2[7]}}, ~c_d2[7], c_d2[6:1]};
`ifdef CVBS_SETUP_EN
        ped  = (state == ACTIVE && !pal_d2) ? {3'b000, SETUP_LVL} : '0;
`else
        ped  = '0;
`endif
        sum  = {3'b000, BLANK_LVL} + ys + cs + ped;
        if (sum[10] || sum == '0)
            level = 8'd1;
        else if (sum[9:8] != 2'b00)
            level = 8'd255;
        else
            level = sum[7:0];
    end

`ifdef CVBS_SETUP_EN
    assign unused_ok = ^{bus.hsync_in, prod[7:0]};
`else
    assign unused_ok = ^{bus.hsync_in, prod[7:0], SETUP_LVL, pal_d2};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.cvbs    <= '0;
            bus.blank_o <= 1'b1;
            bus.sync_o  <= 1'b0;
        end else begin
            bus.cvbs    <= (state == SYNC) ? 8'd0 : level;
            bus.blank_o <= (state != ACTIVE);
            bus.sync_o  <= sy_d2;
        end
    end
endmodule

// File: doc/yc_cvbs_mix.md
YC_CVBS_MIX -- requirements
Module: yc_cvbs_mix

Interface
REQ-001 SHALL have parameter BP_LEN, default 11'd400; clocks from sync end to start of active video (back porch, burst window).
REQ-002 SHALL have parameter BLANK_LVL, default 8'd72; blanking/black level code.
REQ-003 SHALL have parameter SETUP_LVL, default 8'd10; NTSC pedestal code (used only under REQ-022).
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 pal_en  in  1  1 = PAL, 0 = NTSC.
REQ-007 y_in  in  8  luma, unsigned, 0 = black.
REQ-008 c_in  in  8  modulated chroma plus burst, offset binary, 128 = zero.
REQ-009 hsync_in / vsync_in / csync_in  in  1 each  active-high syncs, time-aligned with y_in/c_in.
REQ-010 cvbs  out  8  composite video code, 0 = sync tip.
REQ-011 blank_o  out  1  high when cvbs is not active picture.
REQ-012 sync_o  out  1  csync delayed to align with cvbs.

Function
REQ-013 SHALL use a 2-stage csync qualifier: state changes only after csync_in holds its new value 2 consecutive clocks; 1-clock glitches are ignored.
REQ-014 SHALL run a line FSM with states SYNC, PORCH, ACTIVE, VBL on qualified csync (csq) and vsync_in.
REQ-015 Transitions: any state with csq=1 -> SYNC; SYNC with csq=0 -> PORCH, counter cleared to 0; PORCH -> ACTIVE when counter == BP_LEN-1 and vsync_in=0; PORCH -> VBL when counter == BP_LEN-1 and vsync_in=1; VBL/ACTIVE hold until csq=1.
REQ-016 Counter SHALL be 11 bits, increment only in PORCH, saturate at 2047 (no wrap).
REQ-017 Luma term SHALL be ys = (y_in * 183) >> 8 (0..182), forced to 0 outside ACTIVE.
REQ-018 Chroma term SHALL be cs = signed(c_in - 128) >>> 1 (-64..63), passed in PORCH, ACTIVE and VBL, forced to 0 in SYNC.
REQ-019 Sum SHALL be 11-bit signed BLANK_LVL + ys + cs (+ setup per REQ-022), clamped to [1,255]; in SYNC cvbs SHALL be exactly 0 regardless of inputs.
REQ-020 Latency SHALL be 3 clocks from y_in/c_in/csync_in to cvbs, blank_o and sync_o, all three mutually aligned; FSM decision uses the qualified csync so qualifier delay is absorbed in this budget.
REQ-021 blank_o SHALL be 1 in SYNC, PORCH and VBL; 0 only in ACTIVE.

Configuration
REQ-022 With macro CVBS_SETUP_EN defined, SETUP_LVL SHALL be added to the sum in ACTIVE when pal_en=0; with it undefined, or pal_en=1, no pedestal is added and the SETUP_LVL parameter is unused.

Reset
REQ-023 On reset: FSM = SYNC, counter = 0, qualifier = 0, pipeline cleared; cvbs = 0, blank_o = 1, sync_o = 0 on the clock after reset is sampled high.
REQ-024 Reset mid-line SHALL discard in-flight pipeline data; after release the FSM stays in SYNC until csq=0 then proceeds per REQ-015, so the first post-reset line never shows ACTIVE before a full PORCH.
REQ-025 pal_en changes SHALL take effect on the next pixel without resetting the FSM.

Verification
REQ-026 csync_in high 10 clk, then low, y_in=255, c_in=128, vsync=0 -> cvbs=0 during sync, 72 for 400 clk, then 254 (NTSC, macro off); blank_o falls with first 254.
REQ-027 Same with CVBS_SETUP_EN, pal_en=0, y_in=255 -> ACTIVE cvbs clamps to 255; y_in=0 -> 82; pal_en=1, y_in=0 -> 72.
REQ-028 ACTIVE, y_in=0, c_in=0 -> cvbs=8 (72-64); y_in=255, c_in=255 -> 255 (clamped); PORCH, c_in=0 -> cvbs=8 with y_in ignored.
REQ-029 1-clock csync_in pulse during ACTIVE -> no state change, cvbs unaffected; 2-clock pulse -> SYNC entered, cvbs=0.
REQ-030 vsync_in=1 across line -> state VBL after PORCH, cvbs = 72 + cs, blank_o stays 1 whole line.
REQ-031 reset asserted at mid-ACTIVE -> next clock cvbs=0, blank_o=1; after release with csync_in low, cvbs=72 for exactly BP_LEN clocks (plus latency) before active video.
